// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: 2-flop synchronizer followed by an independent
// debounce FSM per channel producing a clean level plus rise/fall pulses.

module switch_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES+1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  output logic level,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES-1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, rise_nxt, fall_nxt;
  logic             done;

  assign done = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Any sample disagreeing with the candidate level drops back to the stable
  // state, so a bounce restarts qualification with no partial credit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      STABLE_LO: if (sync) begin
        state_nxt = WAIT_HI;
        cnt_nxt   = '0;
      end
      WAIT_HI: begin
        if (!sync)     state_nxt = STABLE_LO;
        else if (done) state_nxt = STABLE_HI;
        else           cnt_nxt   = cnt + CNT_W'(1);
      end
      STABLE_HI: if (!sync) begin
        state_nxt = WAIT_LO;
        cnt_nxt   = '0;
      end
      WAIT_LO: begin
        if (sync)      state_nxt = STABLE_HI;
        else if (done) state_nxt = STABLE_LO;
        else           cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = STABLE_LO;
    endcase
  end

  always_comb begin
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (state == WAIT_HI && sync && done) begin
      level_nxt = 1'b1;
      rise_nxt  = 1'b1;
    end
    if (state == WAIT_LO && !sync && done) begin
      level_nxt = 1'b0;
      fall_nxt  = 1'b1;
    end
  end

endmodule

module switch_debouncer #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES+1);

  logic [WIDTH-1:0] sw_meta, sw_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    switch_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .sync (sw_sync[g]),
      .level(sw_level[g]),
      .rise (sw_rise[g]),
      .fall (sw_fall[g])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=4, WIDTH=2.

module tb_switch_debouncer;

  logic       clk;
  logic       rst_n;
  logic [1:0] sw_in;
  logic [1:0] sw_level, sw_rise, sw_fall;
  int         checks;
  int         errors;

  switch_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_in   (sw_in),
    .sw_level(sw_level),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] lvl, input logic [1:0] r,
                         input logic [1:0] f);
    chk({tag, "_level"}, sw_level, lvl);
    chk({tag, "_rise"},  sw_rise,  r);
    chk({tag, "_fall"},  sw_fall,  f);
  endtask

  // Step n edges; the pulse (r/f) and new level appear exactly at index hit
  // (hit<0: no change expected anywhere in the window).
  task automatic watch(input string tag, input int n, input int hit,
                       input logic [1:0] lvl_pre, input logic [1:0] lvl_post,
                       input logic [1:0] r, input logic [1:0] f);
    for (int e = 0; e < n; e++) begin
      tick();
      if (hit < 0 || e < hit) chk_out(tag, lvl_pre, 2'b00, 2'b00);
      else if (e == hit)      chk_out(tag, lvl_post, r, f);
      else                    chk_out(tag, lvl_post, 2'b00, 2'b00);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    sw_in  = 2'b00;

    // 1: reset state and idle
    repeat (3) tick();
    chk_out("reset", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    watch("idle", 20, -1, 2'b00, 2'b00, 2'b00, 2'b00);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst_idle", 2'b00, 2'b00, 2'b00);
    #1 rst_n = 1'b1;

    // 2: ch0 rise at edge 6, then fall back
    sw_in = 2'b01;
    watch("rise0", 9, 6, 2'b00, 2'b01, 2'b01, 2'b00);
    sw_in = 2'b00;
    watch("fall0", 9, 6, 2'b01, 2'b00, 2'b00, 2'b01);

    // 3: 4-sample pulse rejected; 5-sample pulse accepted
    sw_in = 2'b01;
    watch("short4_hi", 4, -1, 2'b00, 2'b00, 2'b00, 2'b00);
    sw_in = 2'b00;
    watch("short4_lo", 10, -1, 2'b00, 2'b00, 2'b00, 2'b00);
    sw_in = 2'b01;
    watch("p5_hi", 5, -1, 2'b00, 2'b00, 2'b00, 2'b00);
    sw_in = 2'b00;
    watch("p5_rise", 2, 1, 2'b00, 2'b01, 2'b01, 2'b00);
    watch("p5_fall", 6, 4, 2'b01, 2'b00, 2'b00, 2'b01);

    // 4: ch1 high, then bounce 1,0,1,0,0,... -> single fall at edge 9
    sw_in = 2'b10;
    watch("rise1", 8, 6, 2'b00, 2'b10, 2'b10, 2'b00);
    sw_in = 2'b10;
    watch("bnc_e0", 1, -1, 2'b10, 2'b10, 2'b00, 2'b00);
    sw_in = 2'b00;
    watch("bnc_e1", 1, -1, 2'b10, 2'b10, 2'b00, 2'b00);
    sw_in = 2'b10;
    watch("bnc_e2", 1, -1, 2'b10, 2'b10, 2'b00, 2'b00);
    sw_in = 2'b00;
    watch("bnc_fall", 9, 6, 2'b10, 2'b00, 2'b00, 2'b10);

    // 5: both channels together
    sw_in = 2'b11;
    watch("both", 9, 6, 2'b00, 2'b11, 2'b11, 2'b00);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst_hi", 2'b00, 2'b00, 2'b00);
    sw_in = 2'b00;
    #1 rst_n = 1'b1;
    watch("post_rst_idle", 4, -1, 2'b00, 2'b00, 2'b00, 2'b00);

    // 6: reset at WAIT_HI cnt=2 discards progress
    sw_in = 2'b01;
    watch("pre_rst", 5, -1, 2'b00, 2'b00, 2'b00, 2'b00);
    #2 rst_n = 1'b0;
    #1 chk_out("mid_rst", 2'b00, 2'b00, 2'b00);
    #2 rst_n = 1'b1;
    watch("rst_rise", 8, 6, 2'b00, 2'b01, 2'b01, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
